// File: rtl/energy_detect_ctrl.sv
// Energy-detect controller: |I|+|Q| magnitude, fixed-window average and a
// hysteresis/hang-over FSM producing detect level and start-of-burst pulse.
module energy_detect_ctrl #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned LOG_WIN  = 4,
    parameter int unsigned HANG_WIN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             vld,
    input  logic [WIDTH-1:0] i_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] thr_on,
    input  logic [WIDTH-1:0] thr_off,
    output logic [WIDTH-1:0] mag_avg,
    output logic             avg_vld,
    output logic             detect,
    output logic             sof
);

    localparam int unsigned MW  = WIDTH + 1;
    localparam int unsigned AW  = WIDTH + 1 + LOG_WIN;
    localparam int unsigned HW  = 8;
    localparam int unsigned WIN = 2 ** LOG_WIN;

    typedef enum logic [1:0] {IDLE, SEARCH, DETECT, HANG} state_t;

    function automatic logic [WIDTH-1:0] abs_u(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

    logic              s1_vld_q;
    logic [MW-1:0]     m_q;
    logic [AW-1:0]     acc_q;
    logic [AW-1:0]     sum;
    logic [LOG_WIN-1:0] cnt_q;
    logic [AW-1:0]     tot_q;
    logic              tot_vld_q;
    logic [AW-1:0]     shifted;
    logic [WIDTH-1:0]  sat;
    logic [WIDTH-1:0]  mag_avg_q;
    logic              avg_vld_q;
    state_t            state_q, state_d;
    logic [HW-1:0]     hang_q, hang_d, hang_inc;
    logic              detect_q, detect_d;
    logic              sof_q, sof_d;

    // Stage 1: registered magnitude; invalid samples never enter the pipe
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            s1_vld_q <= 1'b0;
            m_q      <= '0;
        end else begin
            s1_vld_q <= vld;
            if (vld) begin
                m_q <= MW'(abs_u(i_in)) + MW'(abs_u(q_in));
            end
        end
    end

    // Stage 2: window accumulator; the closing sample is folded into the total
    assign sum = acc_q + AW'(m_q);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            tot_q     <= '0;
            tot_vld_q <= 1'b0;
        end else begin
            tot_vld_q <= 1'b0;
            if (s1_vld_q) begin
                if (cnt_q == LOG_WIN'(WIN - 1)) begin
                    acc_q     <= '0;
                    cnt_q     <= '0;
                    tot_q     <= sum;
                    tot_vld_q <= 1'b1;
                end else begin
                    acc_q <= sum;
                    cnt_q <= cnt_q + LOG_WIN'(1);
                end
            end
        end
    end

    // Stage 3: truncating average, saturated to the output width
    assign shifted = tot_q >> LOG_WIN;
    assign sat     = (|shifted[AW-1:WIDTH]) ? '1 : shifted[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_avg_q <= '0;
            avg_vld_q <= 1'b0;
        end else if (!en) begin
            avg_vld_q <= 1'b0;
        end else begin
            avg_vld_q <= tot_vld_q;
            if (tot_vld_q) begin
                mag_avg_q <= sat;
            end
        end
    end

    assign hang_inc = hang_q + HW'(1);

    always_comb begin
        state_d = state_q;
        hang_d  = hang_q;
        sof_d   = 1'b0;
        if (!en) begin
            state_d = IDLE;
            hang_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SEARCH;
                    hang_d  = '0;
                end
                SEARCH: begin
                    if (avg_vld_q && (mag_avg_q >= thr_on)) begin
                        state_d = DETECT;
                        sof_d   = 1'b1;
                    end
                end
                DETECT: begin
                    if (avg_vld_q && (mag_avg_q < thr_off)) begin
                        state_d = HANG;
                        hang_d  = HW'(1);
                    end
                end
                HANG: begin
                    // HANG_WIN=1 enters already exhausted and leaves unconditionally
                    if (hang_q >= HW'(HANG_WIN)) begin
                        state_d = SEARCH;
                        hang_d  = '0;
                    end else if (avg_vld_q) begin
                        if (mag_avg_q >= thr_off) begin
                            state_d = DETECT;
                            hang_d  = '0;
                        end else if (hang_inc >= HW'(HANG_WIN)) begin
                            state_d = SEARCH;
                            hang_d  = '0;
                        end else begin
                            hang_d = hang_inc;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    hang_d  = '0;
                end
            endcase
        end
        detect_d = (state_d == DETECT) || (state_d == HANG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            hang_q   <= '0;
            detect_q <= 1'b0;
            sof_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hang_q   <= hang_d;
            detect_q <= detect_d;
            sof_q    <= sof_d;
        end
    end

    assign mag_avg = mag_avg_q;
    assign avg_vld = avg_vld_q;
    assign detect  = detect_q;
    assign sof     = sof_q;

endmodule

// File: tb/tb_energy_detect_ctrl.sv
// Directed bench for energy_detect_ctrl; window averages are predicted at
// stimulus time and checked against each avg_vld strobe.
module tb_energy_detect_ctrl;

    logic        clk = 1'b0;
    logic        rst, en, vld;
    logic [15:0] i_in, q_in, thr_on, thr_off;
    logic [15:0] mag_avg;
    logic        avg_vld, detect, sof;

    typedef struct {
        int unsigned avg;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned macc = 0;
    int unsigned mcnt = 0;
    int unsigned strobe_cnt = 0, sof_cnt = 0, fall_cnt = 0;
    int unsigned last_strobe_cyc = 0, fall_cyc = 0;
    logic        prev_sof = 1'b0, prev_det = 1'b0;

    energy_detect_ctrl #(.WIDTH(16), .LOG_WIN(4), .HANG_WIN(2)) dut (
        .clk(clk), .rst(rst), .en(en), .vld(vld),
        .i_in(i_in), .q_in(q_in), .thr_on(thr_on), .thr_off(thr_off),
        .mag_avg(mag_avg), .avg_vld(avg_vld), .detect(detect), .sof(sof)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one sample for one cycle and update the reference window model
    task automatic drive(input logic v, input int iv, input int qv);
        int unsigned m;
        int unsigned a;
        vld  = v;
        i_in = 16'(iv);
        q_in = 16'(qv);
        if (!rst) begin
            if (!en) begin
                macc = 0;
                mcnt = 0;
            end else if (v) begin
                m = ((iv < 0) ? -iv : iv) + ((qv < 0) ? -qv : qv);
                macc += m;
                mcnt++;
                if (mcnt == 16) begin
                    a = macc >> 4;
                    if (a > 65535) a = 65535;
                    sb.push_back('{avg: a, cyc: cyc});
                    macc = 0;
                    mcnt = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, int'($urandom_range(0, 65535)) - 32768,
                         int'($urandom_range(0, 65535)) - 32768);
    endtask

    task automatic window(input int iv, input int qv);
        repeat (16) drive(1'b1, iv, qv);
    endtask

    // Output monitor: scoreboard pop on each strobe, sof/detect bookkeeping
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (avg_vld) begin
                strobe_cnt++;
                last_strobe_cyc = cyc;
                chk("strobe_expected", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("mag_avg", 32'(mag_avg), e.avg);
                    chk("avg_latency", cyc, e.cyc + 3);
                end
            end
            if (sof) begin
                sof_cnt++;
                chk("sof_with_detect", 32'(detect), 1);
                chk("sof_single", 32'(prev_sof), 0);
                chk("sof_latency", cyc, last_strobe_cyc + 1);
            end
            if (prev_det && !detect) begin
                fall_cnt++;
                fall_cyc = cyc;
            end
            prev_sof = sof;
            prev_det = detect;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; vld = 1'b1;
        i_in = '0; q_in = '0;
        thr_on = 16'd1500; thr_off = 16'd1000;

        // 1: reset with live random data
        repeat (3) drive(1'b1, int'($urandom_range(0, 65535)) - 32768,
                         int'($urandom_range(0, 65535)) - 32768);
        @(negedge clk);
        chk("rst_detect", 32'(detect), 0);
        chk("rst_sof", 32'(sof), 0);
        chk("rst_avg_vld", 32'(avg_vld), 0);
        chk("rst_mag_avg", 32'(mag_avg), 0);
        rst = 1'b0;

        // 2: continuous 2000-magnitude windows, single sof
        repeat (6) window(1000, -1000);
        idle(4);
        chk("t2_strobes", strobe_cnt, 6);
        chk("t2_sof_cnt", sof_cnt, 1);
        chk("t2_detect", 32'(detect), 1);
        chk("t2_no_drop", fall_cnt, 0);

        // 3: most-negative inputs saturate the average
        window(-32768, -32768);
        idle(4);
        chk("t3_detect", 32'(detect), 1);

        // 4a: two low windows drop detect via HANG
        window(250, 250);
        idle(4);
        chk("t4_hang_detect", 32'(detect), 1);
        chk("t4_hang_no_drop", fall_cnt, 0);
        window(250, 250);
        idle(4);
        chk("t4_drop_detect", 32'(detect), 0);
        chk("t4_drop_cnt", fall_cnt, 1);
        chk("t4_drop_latency", fall_cyc, last_strobe_cyc + 1);

        // 4b: low then recovering window returns to DETECT without sof
        window(1000, -1000);
        idle(4);
        chk("t4_redetect_sof", sof_cnt, 2);
        window(250, 250);
        idle(4);
        window(600, 600);
        idle(4);
        window(600, 600);
        idle(4);
        chk("t4_recover_detect", 32'(detect), 1);
        chk("t4_recover_no_drop", fall_cnt, 1);
        chk("t4_recover_no_sof", sof_cnt, 2);

        // 5: vld toggling with garbage on invalid cycles
        begin
            int unsigned s0;
            s0 = strobe_cnt;
            repeat (16) begin
                drive(1'b1, 1000, -1000);
                drive(1'b0, int'($urandom_range(0, 65535)) - 32768,
                      int'($urandom_range(0, 65535)) - 32768);
            end
            idle(4);
            chk("t5_one_strobe", strobe_cnt, s0 + 1);
        end

        // 6: en dropped after 9 samples of a window
        repeat (9) drive(1'b1, 8000, 8000);
        en = 1'b0;
        drive(1'b1, 8000, 8000);
        @(negedge clk);
        chk("t6_off_detect", 32'(detect), 0);
        chk("t6_off_sof", 32'(sof), 0);
        chk("t6_off_avg_vld", 32'(avg_vld), 0);
        chk("t6_mag_hold", 32'(mag_avg), 2000);
        drive(1'b1, 8000, 8000);
        en = 1'b1;
        window(1000, -1000);
        idle(4);
        chk("t6_search_sof", sof_cnt, 3);
        chk("t6_detect", 32'(detect), 1);

        idle(8);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
